// File: rtl/block_mult_engine.sv
// Block-matrix multiply engine: fetches A/B tiles over a shared bus,
// accumulates C(i,j) locally, writes it back. Option: BLOCK_MULT_SATURATE_EN.
module block_mult_engine #(
    parameter int SIZE           = 4,
    parameter int CELL_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int A_BASE         = 0,
    parameter int B_BASE         = 256,
    parameter int C_BASE         = 512,
    parameter int WIDTH          = CELL_WIDTH * SIZE
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic [INDEX_WIDTH-1:0]    in_row_index,
    input  logic [INDEX_WIDTH-1:0]    in_col_index,
    input  logic [INDEX_WIDTH-1:0]    in_mu,
    input  logic                      in_index_ready,
    output logic                      out_index_ack,
    output logic                      out_result_ready,
    output logic                      out_request,
    input  logic                      in_grant,
    output logic                      out_mem_read_en,
    output logic                      out_mem_write_en,
    output logic [MEM_ADDR_WIDTH-1:0] out_mem_address,
    output logic [WIDTH-1:0]          out_mem_data,
    input  logic [WIDTH-1:0]          in_mem_data
);

    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE - 1);
    localparam int PW = 2 * CELL_WIDTH;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] MAC   = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]             state;
    logic [INDEX_WIDTH-1:0] ti, tj, tmu, tx;
    logic [RW-1:0]          rd_row, pend_row, wr_row, mr, mk;
    logic                   rd_b, rd_done, pend, pend_b;
    logic                   rd_go, wr_go;
    logic [WIDTH-1:0]       wr_data;

    logic signed [CELL_WIDTH-1:0] a_t [SIZE][SIZE];
    logic signed [CELL_WIDTH-1:0] b_t [SIZE][SIZE];
    logic signed [CELL_WIDTH-1:0] c_t [SIZE][SIZE];

    // Row address of tile (tr, tc), row r, wrapped to the bus width.
    function automatic logic [MEM_ADDR_WIDTH-1:0] tile_addr(
        input int                     base,
        input logic [INDEX_WIDTH-1:0] tr,
        input logic [INDEX_WIDTH-1:0] tc,
        input logic [INDEX_WIDTH-1:0] m,
        input logic [RW-1:0]          r
    );
        logic [31:0] t;
        t = 32'(base) + (32'(tr) * 32'(m) + 32'(tc)) * 32'(SIZE) + 32'(r);
        return t[MEM_ADDR_WIDTH-1:0];
    endfunction

    // One accumulate step: wide sum, then wrap or clamp to a cell.
    function automatic logic signed [CELL_WIDTH-1:0] acc_op(
        input logic signed [CELL_WIDTH-1:0] acc,
        input logic signed [PW-1:0]         p
    );
        logic signed [PW:0] s;
        s = (PW + 1)'(acc) + (PW + 1)'(p);
`ifdef BLOCK_MULT_SATURATE_EN
        if (s > $signed({{(CELL_WIDTH + 2){1'b0}}, {(CELL_WIDTH - 1){1'b1}}}))
            return {1'b0, {(CELL_WIDTH - 1){1'b1}}};
        else if (s < $signed({{(CELL_WIDTH + 2){1'b1}}, {(CELL_WIDTH - 1){1'b0}}}))
            return {1'b1, {(CELL_WIDTH - 1){1'b0}}};
        else
            return s[CELL_WIDTH-1:0];
`else
        return s[CELL_WIDTH-1:0];
`endif
    endfunction

    assign rd_go = !in_reset && (state == LOAD) && !rd_done && in_grant;
    assign wr_go = !in_reset && (state == WRITE) && in_grant;

    assign out_index_ack    = !in_reset && (state == IDLE) && in_index_ready;
    assign out_result_ready = !in_reset && (state == DONE);
    assign out_request      = !in_reset && ((state == LOAD) || (state == WRITE));

    // Bus drive: strobes, address and data are zero unless a granted access.
    always_comb begin
        wr_data          = '0;
        out_mem_read_en  = 1'b0;
        out_mem_write_en = 1'b0;
        out_mem_address  = '0;
        out_mem_data     = '0;
        for (int c = 0; c < SIZE; c++)
            wr_data[c*CELL_WIDTH +: CELL_WIDTH] = c_t[wr_row][c];
        if (rd_go) begin
            out_mem_read_en = 1'b1;
            out_mem_address = rd_b ? tile_addr(B_BASE, tx, tj, tmu, rd_row)
                                   : tile_addr(A_BASE, ti, tx, tmu, rd_row);
        end else if (wr_go) begin
            out_mem_write_en = 1'b1;
            out_mem_address  = tile_addr(C_BASE, ti, tj, tmu, wr_row);
            out_mem_data     = wr_data;
        end
    end

    // Job sequencer: tile fetch, MAC sweep, write-back and completion.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state    <= IDLE;
            ti       <= '0;
            tj       <= '0;
            tmu      <= '0;
            tx       <= '0;
            rd_row   <= '0;
            rd_b     <= 1'b0;
            rd_done  <= 1'b0;
            pend     <= 1'b0;
            pend_b   <= 1'b0;
            pend_row <= '0;
            wr_row   <= '0;
            mr       <= '0;
            mk       <= '0;
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    c_t[r][c] <= '0;
        end else begin
            pend     <= rd_go;
            pend_b   <= rd_b;
            pend_row <= rd_row;
            if (pend) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (pend_b)
                        b_t[pend_row][c] <= in_mem_data[c*CELL_WIDTH +: CELL_WIDTH];
                    else
                        a_t[pend_row][c] <= in_mem_data[c*CELL_WIDTH +: CELL_WIDTH];
                end
            end
            case (state)
                IDLE: begin
                    if (in_index_ready) begin
                        ti      <= in_row_index;
                        tj      <= in_col_index;
                        tmu     <= in_mu;
                        tx      <= '0;
                        rd_row  <= '0;
                        rd_b    <= 1'b0;
                        rd_done <= 1'b0;
                        wr_row  <= '0;
                        mr      <= '0;
                        mk      <= '0;
                        for (int r = 0; r < SIZE; r++)
                            for (int c = 0; c < SIZE; c++)
                                c_t[r][c] <= '0;
                        state <= (in_mu != '0) ? LOAD : WRITE;
                    end
                end
                LOAD: begin
                    if (rd_go) begin
                        if (rd_row == LAST_ROW) begin
                            rd_row <= '0;
                            if (rd_b)
                                rd_done <= 1'b1;
                            else
                                rd_b <= 1'b1;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end
                    if (pend && pend_b && (pend_row == LAST_ROW)) begin
                        mr    <= '0;
                        mk    <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    for (int c = 0; c < SIZE; c++)
                        c_t[mr][c] <= acc_op(c_t[mr][c],
                            PW'(a_t[mr][mk]) * PW'(b_t[mk][c]));
                    if (mk == LAST_ROW) begin
                        mk <= '0;
                        if (mr == LAST_ROW) begin
                            mr      <= '0;
                            tx      <= tx + 1'b1;
                            rd_row  <= '0;
                            rd_b    <= 1'b0;
                            rd_done <= 1'b0;
                            state   <= (({1'b0, tx} + 1'b1) < {1'b0, tmu})
                                       ? LOAD : WRITE;
                        end else begin
                            mr <= mr + 1'b1;
                        end
                    end else begin
                        mk <= mk + 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_go) begin
                        if (wr_row == LAST_ROW) begin
                            wr_row <= '0;
                            state  <= DONE;
                        end else begin
                            wr_row <= wr_row + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_mult_engine.sv
// Directed bench for block_mult_engine: vector table of tile jobs
// plus grant-stall and mid-job reset sequences.
module tb_block_mult_engine;

    localparam int SIZE = 4;
    localparam int CW = 32;
    localparam int IW = 8;
    localparam int AW = 10;
    localparam int WIDTH = CW * SIZE;
    localparam int A_BASE = 0;
    localparam int B_BASE = 256;
    localparam int C_BASE = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic [IW-1:0]    row_index, col_index, mu;
    logic             index_ready;
    logic             index_ack, result_ready, request, grant;
    logic             mem_read_en, mem_write_en;
    logic [AW-1:0]    mem_address;
    logic [WIDTH-1:0] mem_data, rdata;

    logic [WIDTH-1:0] mem [1024];
    logic             bd_we, bd_clr;
    logic [AW-1:0]    bd_addr;
    logic [WIDTH-1:0] bd_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        int kind;
        int i;
        int j;
        int m;
        int lat;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    block_mult_engine dut (
        .in_clk(clk),
        .in_reset(rst),
        .in_row_index(row_index),
        .in_col_index(col_index),
        .in_mu(mu),
        .in_index_ready(index_ready),
        .out_index_ack(index_ack),
        .out_result_ready(result_ready),
        .out_request(request),
        .in_grant(grant),
        .out_mem_read_en(mem_read_en),
        .out_mem_write_en(mem_write_en),
        .out_mem_address(mem_address),
        .out_mem_data(mem_data),
        .in_mem_data(rdata)
    );

    // Memory model: one-cycle read latency, plus backdoor fill port.
    always @(posedge clk) begin
        if (bd_clr) begin
            for (int a = 0; a < 1024; a++) mem[a] <= '0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_write_en) begin
            mem[mem_address] <= mem_data;
        end
        if (mem_read_en) rdata <= mem[mem_address];
        else rdata <= '0;
    end

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] row4(input logic [31:0] c0,
        input logic [31:0] c1, input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [WIDTH-1:0] ident(input int r, input logic [31:0] s);
        return row4(r == 0 ? s : 0, r == 1 ? s : 0, r == 2 ? s : 0, r == 3 ? s : 0);
    endfunction

    function automatic logic [31:0] exp_cell(input int kind, input int r, input int c);
        case (kind)
            0: return 32'(4 * r + c - 8);
            1: return 32'd3;
            2: begin
                if (r == 0 && c == 0) begin
`ifdef BLOCK_MULT_SATURATE_EN
                    return 32'h7FFF_FFFF;
`else
                    return 32'hFFFF_FFFE;
`endif
                end
                return 32'd0;
            end
            4: return 32'd13;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int c_addr(input int i, input int j, input int m, input int r);
        return (C_BASE + (i * m + j) * SIZE + r) % 1024;
    endfunction

    task automatic bd(input logic we, input logic clr, input int addr,
                      input logic [WIDTH-1:0] d);
        @(negedge clk);
        bd_we = we;
        bd_clr = clr;
        bd_addr = AW'(addr);
        bd_data = d;
    endtask

    task automatic fill_mem(input int kind, input int i, input int j, input int m);
        logic [31:0] bv [3];
        bv[0] = 32'd5;
        bv[1] = -32'sd2;
        bv[2] = 32'd10;
        bd(1'b0, 1'b1, 0, '0);
        for (int r = 0; r < SIZE; r++) begin
            case (kind)
                0: begin
                    bd(1'b1, 1'b0, A_BASE + r, ident(r, 1));
                    bd(1'b1, 1'b0, B_BASE + r, row4(32'(4*r-8), 32'(4*r-7),
                                                    32'(4*r-6), 32'(4*r-5)));
                end
                1: begin
                    bd(1'b1, 1'b0, A_BASE + r, ident(r, 1));
                    bd(1'b1, 1'b0, A_BASE + 4 + r, ident(r, 2));
                    bd(1'b1, 1'b0, B_BASE + r, row4(1, 1, 1, 1));
                    bd(1'b1, 1'b0, B_BASE + 8 + r, row4(1, 1, 1, 1));
                end
                2: begin
                    if (r == 0) begin
                        bd(1'b1, 1'b0, A_BASE, row4(32'h7FFF_FFFF, 0, 0, 0));
                        bd(1'b1, 1'b0, B_BASE, row4(2, 0, 0, 0));
                    end
                end
                4: begin
                    for (int x = 0; x < 3; x++) begin
                        bd(1'b1, 1'b0, A_BASE + (3 + x) * 4 + r, ident(r, 1));
                        bd(1'b1, 1'b0, B_BASE + (3 * x + 2) * 4 + r,
                           row4(bv[x], bv[x], bv[x], bv[x]));
                    end
                end
                default: ;
            endcase
            bd(1'b1, 1'b0, c_addr(i, j, m, r), {4{32'hA5A5_5A5A}});
        end
        bd(1'b0, 1'b0, 0, '0);
    endtask

    task automatic check_tile(input string name, input int kind, input int i,
                              input int j, input int m);
        for (int r = 0; r < SIZE; r++)
            chk(name, mem[c_addr(i, j, m, r)],
                row4(exp_cell(kind, r, 0), exp_cell(kind, r, 1),
                     exp_cell(kind, r, 2), exp_cell(kind, r, 3)));
    endtask

    task automatic run_job(input int i, input int j, input int m,
                           input int ls, input int ll, input int ws, input int wl,
                           output int lat, output int extra_ack, output int sbad);
        lat = -1;
        extra_ack = 0;
        sbad = 0;
        @(negedge clk);
        row_index = IW'(i);
        col_index = IW'(j);
        mu = IW'(m);
        index_ready = 1'b1;
        grant = 1'b1;
        #1;
        chk("ack", 128'(index_ack), 128'(1));
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            row_index = 8'hEE;
            col_index = 8'hDD;
            mu = 8'h07;
            grant = !((n >= ls && n < ls + ll) || (n >= ws && n < ws + wl));
            #1;
            if (index_ack) extra_ack++;
            if (!grant && (mem_read_en || mem_write_en)) sbad++;
            if (result_ready) begin
                lat = n;
                break;
            end
        end
        index_ready = 1'b0;
        grant = 1'b1;
    endtask

    initial begin
        int lat, xa, sb, stale;
        vecs[0] = '{kind: 0, i: 0, j: 0, m: 1, lat: 30};
        vecs[1] = '{kind: 1, i: 0, j: 0, m: 2, lat: 55};
        vecs[2] = '{kind: 2, i: 0, j: 0, m: 1, lat: 30};
        vecs[3] = '{kind: 3, i: 3, j: 1, m: 0, lat: 5};
        vecs[4] = '{kind: 4, i: 1, j: 2, m: 3, lat: 80};

        rst = 1'b1;
        index_ready = 1'b0;
        row_index = '0;
        col_index = '0;
        mu = '0;
        grant = 1'b1;
        bd_we = 1'b0;
        bd_clr = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ack", 128'(index_ack), 128'(0));
        chk("rst_result", 128'(result_ready), 128'(0));
        chk("rst_request", 128'(request), 128'(0));
        chk("rst_strobes", 128'({mem_read_en, mem_write_en}), 128'(0));
        chk("rst_address", 128'(mem_address), 128'(0));
        chk("rst_data", mem_data, '0);

        for (int v = 0; v < 5; v++) begin
            fill_mem(vecs[v].kind, vecs[v].i, vecs[v].j, vecs[v].m);
            run_job(vecs[v].i, vecs[v].j, vecs[v].m, 0, 0, 0, 0, lat, xa, sb);
            chk("latency", 128'(lat), 128'(vecs[v].lat));
            chk("extra_ack", 128'(xa), 128'(0));
            @(negedge clk);
            check_tile("c_tile", vecs[v].kind, vecs[v].i, vecs[v].j, vecs[v].m);
        end

        fill_mem(0, 0, 0, 1);
        run_job(0, 0, 1, 3, 3, 30, 2, lat, xa, sb);
        chk("stall_latency", 128'(lat), 128'(35));
        chk("stall_strobes", 128'(sb), 128'(0));
        @(negedge clk);
        check_tile("stall_tile", 0, 0, 0, 1);

        fill_mem(1, 0, 0, 2);
        @(negedge clk);
        row_index = '0;
        col_index = '0;
        mu = 8'd2;
        index_ready = 1'b1;
        @(negedge clk);
        index_ready = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            #1;
            if (result_ready || request) stale++;
        end
        chk("no_stale", 128'(stale), 128'(0));
        fill_mem(0, 0, 0, 1);
        run_job(0, 0, 1, 0, 0, 0, 0, lat, xa, sb);
        chk("post_rst_latency", 128'(lat), 128'(30));
        @(negedge clk);
        check_tile("post_rst_tile", 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_mult_engine.md
# block_mult_engine

Parametrised block-matrix multiply engine: accepts a tile job (i, j, mu) from the main control unit, fetches tiles A(i,x) and B(x,j) for x = 0..mu-1 over the shared arbitrated memory bus, and accumulates C(i,j) = Σ A(i,x)·B(x,j) in a local tile accumulator. It then writes C(i,j) back and signals completion. It replaces the fixed CU/register-file/multiplier processing element with a single self-sequencing unit, adding bus release between fetch and compute, grant-loss stall and optional saturating accumulation.

## Interface
- SIZE, 4, tile dimension (SIZE×SIZE cells)
- CELL_WIDTH, 32, signed two's-complement cell width
- INDEX_WIDTH, 8, width of i, j, mu
- MEM_ADDR_WIDTH, 10, memory row address width
- A_BASE / B_BASE / C_BASE, 0 / 256 / 512, base row address of each matrix
- WIDTH, CELL_WIDTH*SIZE, memory row width (one tile row per address)

Ports:
- in_clk  in  1  clock; one clock, all logic on rising edge
- in_reset  in  1  synchronous, active-high reset
- in_row_index / in_col_index  in  INDEX_WIDTH  tile indices i, j
- in_mu  in  INDEX_WIDTH  tiles per grid side; inner-product length
- in_index_ready  in  1  job valid (level)
- out_index_ack  out  1  one-cycle pulse, job accepted
- out_result_ready  out  1  one-cycle pulse, C written
- out_request  out  1  bus request to arbiter
- in_grant  in  1  bus granted this cycle
- out_mem_read_en / out_mem_write_en  out  1  memory strobes
- out_mem_address  out  MEM_ADDR_WIDTH  row address
- out_mem_data  out  WIDTH  write data
- in_mem_data  in  WIDTH  read data, valid the cycle after read_en

## Operation
- Cell c of a row occupies bits [c*CELL_WIDTH +: CELL_WIDTH].
- Tile (tr, tc), row r address = base + (tr*mu + tc)*SIZE + r, computed modulo 2^MEM_ADDR_WIDTH.
- States: IDLE, LOAD, MAC, WRITE, DONE.
- IDLE: if in_index_ready, latch i, j, mu, pulse out_index_ack, clear accumulator and x. Go to LOAD if mu≠0, else WRITE (zero tile).
- LOAD: out_request=1. Issue 2*SIZE reads: A(i,x) rows 0..SIZE-1, then B(x,j) rows 0..SIZE-1. A read is issued only in a cycle with in_grant=1. If grant drops, the read address and counter hold. Data is captured the following cycle regardless of grant. After the last capture, go to MAC.
- MAC: out_request=0; bus outputs idle. Step (r,k) runs r outer, k inner, SIZE*SIZE cycles. Each cycle does C[r][c] ← acc_op(C[r][c], A[r][k]*B[k][c]) for all c (SIZE multipliers). Then x+1: go to LOAD if x<mu, else WRITE.
- Arithmetic: product is 2*CELL_WIDTH signed; sum is formed at 2*CELL_WIDTH+1, then reduced to CELL_WIDTH per Configuration.
- WRITE: out_request=1. Write C rows 0..SIZE-1 to tile (i,j) of C_BASE, one per granted cycle. Grant loss stalls as in LOAD. Then go to DONE.
- DONE: pulse out_result_ready, go to IDLE. The next ack can occur no earlier than the following cycle.
- Bus outputs (strobes, address, data) are 0 whenever in_grant=0 or out_request=0.
- Reset (any state): state IDLE; accumulator and counters cleared; an in-flight job is discarded with no ack or result pulse.

## Timing
- Reset values: out_index_ack=0, out_result_ready=0, out_request=0, read/write_en=0, address=0, data=0.
- out_request rises the cycle after the ack (T0+1) and in the cycle MAC exits to LOAD/WRITE.
- With in_grant held 1: out_result_ready at T0 + 1 + mu*(2*SIZE+1+SIZE*SIZE) + SIZE.
- Each grant-low cycle during LOAD/WRITE adds exactly one cycle.
- in_index_ready is ignored outside IDLE; fields are sampled only in the ack cycle.

## Configuration
- BLOCK_MULT_SATURATE_EN defined: each accumulate clamps to [-2^(CELL_WIDTH-1), 2^(CELL_WIDTH-1)-1].
- Not defined: each accumulate keeps the low CELL_WIDTH bits (wrap-around).

## Test plan
- SIZE=4, mu=1, i=j=0, A=identity, B cells b[r][c]=4r+c-8 -> C row r = B row r at C_BASE+r; result_ready at T0+30.
- mu=2, A(0,x)=identity·(x+1), B(x,0)=all 1 -> every C cell =3; result_ready at T0+55.
- A[0][0]=0x7FFFFFFF, B[0][0]=2, rest 0, mu=1 -> C[0][0]=0xFFFFFFFE without the macro, 0x7FFFFFFF with it.
- Grant low for 3 cycles mid-LOAD and 2 cycles mid-WRITE -> same C contents, result_ready 5 cycles later; no strobes while grant=0.
- mu=0 -> C tile all zero written, result_ready at T0+5.
- Reset asserted mid-MAC, then a new job -> no stale result pulse; new C is correct, with no residue from the aborted accumulator.
